// File: rtl/dac_frame_receiver_pkg.sv
// Shared definitions for the DAC serial frame protocol: opcodes, field offsets,
// receiver state encoding and the frame classification helper.
package dac_frame_receiver_pkg;

   localparam int unsigned FRAME_BITS = 32;

   localparam logic [3:0] CTRL_WRITE_UPDATE = 4'b0011;
   localparam logic [3:0] CTRL_REF_SET      = 4'b1001;
   localparam logic [3:0] ADDR_ALL          = 4'hF;

   localparam int unsigned PREFIX_LSB  = 28;
   localparam int unsigned CTRL_LSB    = 24;
   localparam int unsigned ADDR_LSB    = 20;
   localparam int unsigned DATA_LSB    = 4;
   localparam int unsigned FEATURE_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DECODE,
      ST_ERR
   } rx_state_e;

   typedef enum logic [1:0] {
      ACT_WRITE,
      ACT_BCAST,
      ACT_REF,
      ACT_ERR
   } dac_act_e;

   // Address range is tested before broadcast so a 16-channel build treats 4'hF as a plain write.
   function automatic dac_act_e classify(input logic [3:0]  prefix,
                                         input logic [3:0]  ctrl,
                                         input logic [3:0]  addr,
                                         input int unsigned n_chan);
      dac_act_e act;
      act = ACT_ERR;
      if (prefix == 4'h0) begin
         if (ctrl == CTRL_WRITE_UPDATE) begin
            if (32'(addr) < n_chan) begin
               act = ACT_WRITE;
            end else if (addr == ADDR_ALL) begin
               act = ACT_BCAST;
            end
         end else if (ctrl == CTRL_REF_SET) begin
            act = ACT_REF;
         end
      end
      return act;
   endfunction

endpackage

// File: rtl/dac_frame_receiver_pin_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with single-cycle rise/fall
// pulses derived from the synchronised copy.
module pin_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pin_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   // [0],[1] form the synchroniser; [2] is the previous synchronised value.
   logic [2:0] pipe_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= {pipe_q[1:0], pin_i};
      end
   end

   assign sync_o = pipe_q[1];
   assign rise_o = pipe_q[1] & ~pipe_q[2];
   assign fall_o = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/dac_frame_receiver.sv
// Receive end of the DAC serial link: deserialises nsync/sclk/din frames, decodes
// write-and-update / reference-set commands and keeps per-channel shadow registers.
module dac_frame_receiver
   import dac_frame_receiver_pkg::*;
#(
   parameter int unsigned W_DATA  = 16,
   parameter int unsigned W_CHS   = 3,
   parameter int unsigned N_CHAN  = 8,
   parameter int unsigned W_FRAME = FRAME_BITS
) (
   input  logic                     clk_in,
   input  logic                     reset_n_in,
   input  logic                     nsync_in,
   input  logic                     sclk_in,
   input  logic                     din_in,
   output logic [W_DATA-1:0]        data_out,
   output logic [W_CHS-1:0]         channel_out,
   output logic                     data_valid_out,
   output logic                     ref_set_out,
   output logic                     frame_err_out,
   output logic [N_CHAN*W_DATA-1:0] ch_data_out
);

   localparam int unsigned W_CNT = $clog2(W_FRAME + 2);
   localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(W_FRAME);
   localparam logic [W_CNT-1:0] CNT_SAT  = W_CNT'(W_FRAME + 1);

   logic nsync_s, nsync_rise, nsync_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic din_s;

   pin_sync_edge u_sync_nsync (
      .clk_i  (clk_in),
      .rst_ni (reset_n_in),
      .pin_i  (nsync_in),
      .sync_o (nsync_s),
      .rise_o (nsync_rise),
      .fall_o (nsync_fall)
   );

   pin_sync_edge u_sync_sclk (
      .clk_i  (clk_in),
      .rst_ni (reset_n_in),
      .pin_i  (sclk_in),
      .sync_o (sclk_s),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   pin_sync_edge u_sync_din (
      .clk_i  (clk_in),
      .rst_ni (reset_n_in),
      .pin_i  (din_in),
      .sync_o (din_s),
      .rise_o (),
      .fall_o ()
   );

   rx_state_e          state_q, state_d;
   logic [W_FRAME-1:0] sr_q, sr_d;
   logic [W_CNT-1:0]   cnt_q, cnt_d;
   logic               pending_q, pending_d;
   logic [W_DATA-1:0]  shadow_q [N_CHAN];
   logic [W_DATA-1:0]  shadow_d [N_CHAN];
   logic [W_DATA-1:0]  data_q, data_d;
   logic [W_CHS-1:0]   chan_q, chan_d;
   logic               dv_q, dv_d;
   logic               ref_q, ref_d;
   logic               err_q, err_d;

   dac_act_e           act;
   logic [3:0]         addr_f;
   logic [W_DATA-1:0]  data_f;

   assign addr_f = sr_q[ADDR_LSB +: 4];
   assign data_f = sr_q[DATA_LSB +: W_DATA];
   assign act    = classify(sr_q[PREFIX_LSB +: 4], sr_q[CTRL_LSB +: 4], addr_f, N_CHAN);

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         shadow_q  <= '{default: '0};
         data_q    <= '0;
         chan_q    <= '0;
         dv_q      <= 1'b0;
         ref_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         data_q    <= data_d;
         chan_q    <= chan_d;
         dv_q      <= dv_d;
         ref_q     <= ref_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      data_d    = data_q;
      chan_d    = chan_q;
      dv_d      = 1'b0;
      ref_d     = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            pending_d = 1'b0;
            // A frame whose nsync fell during decode/error is picked up here.
            if (nsync_fall || (pending_q && !nsync_s)) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               sr_d    = '0;
            end
         end

         ST_SHIFT: begin
            if (nsync_rise) begin
               state_d = (cnt_q == CNT_FULL) ? ST_DECODE : ST_ERR;
            end else if (sclk_fall) begin
               sr_d = {sr_q[W_FRAME-2:0], din_s};
               if (cnt_q != CNT_SAT) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_DECODE: begin
            state_d   = ST_IDLE;
            pending_d = (pending_q | nsync_fall) & ~sclk_fall;
            unique case (act)
               ACT_WRITE: begin
                  shadow_d[addr_f[W_CHS-1:0]] = data_f;
                  data_d = data_f;
                  chan_d = addr_f[W_CHS-1:0];
                  dv_d   = 1'b1;
               end
               ACT_BCAST: begin
                  shadow_d = '{default: data_f};
                  data_d   = data_f;
                  chan_d   = '0;
                  dv_d     = 1'b1;
               end
               ACT_REF: begin
                  ref_d = 1'b1;
               end
               default: begin
                  err_d = 1'b1;
               end
            endcase
         end

         ST_ERR: begin
            state_d   = ST_IDLE;
            pending_d = (pending_q | nsync_fall) & ~sclk_fall;
            err_d     = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign data_out       = data_q;
   assign channel_out    = chan_q;
   assign data_valid_out = dv_q;
   assign ref_set_out    = ref_q;
   assign frame_err_out  = err_q;

   for (genvar k = 0; k < N_CHAN; k++) begin : g_flat
      assign ch_data_out[k*W_DATA +: W_DATA] = shadow_q[k];
   end

endmodule

// File: tb/tb_dac_frame_receiver.sv
// Randomised frame stimulus for dac_frame_receiver checked against a field-level
// model of the protocol (shadow array, last write, expected pulse per frame).
module tb_dac_frame_receiver;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         nsync, sclk, din;
   logic [15:0]  data_out;
   logic [2:0]   channel_out;
   logic         data_valid_out, ref_set_out, frame_err_out;
   logic [127:0] ch_data_out;

   always #5 clk = ~clk;

   dac_frame_receiver #(
      .W_DATA  (16),
      .W_CHS   (3),
      .N_CHAN  (8),
      .W_FRAME (32)
   ) dut (
      .clk_in         (clk),
      .reset_n_in     (reset_n),
      .nsync_in       (nsync),
      .sclk_in        (sclk),
      .din_in         (din),
      .data_out       (data_out),
      .channel_out    (channel_out),
      .data_valid_out (data_valid_out),
      .ref_set_out    (ref_set_out),
      .frame_err_out  (frame_err_out),
      .ch_data_out    (ch_data_out)
   );

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse monitor: counts high cycles per pulse output and logs write order.
   int unsigned dv_cnt = 0, ref_cnt = 0, err_cnt = 0;
   logic [15:0] dv_log[$];

   always @(negedge clk) begin
      if (reset_n) begin
         if (data_valid_out) begin
            dv_cnt++;
            dv_log.push_back(data_out);
         end
         if (ref_set_out)   ref_cnt++;
         if (frame_err_out) err_cnt++;
         if (data_valid_out || ref_set_out || frame_err_out)
            check_eq("pulse_onehot", 128'($countones({data_valid_out, ref_set_out, frame_err_out})), 128'd1);
      end
   end

   // Reference model
   logic [15:0] m_shadow [8];
   logic [15:0] m_data;
   logic [2:0]  m_chan;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_shadow[i] = '0;
      m_data = '0;
      m_chan = '0;
   endtask

   // 0 = write/broadcast, 1 = ref-set, 2 = error; applies the frame to the model.
   function automatic int model_apply(input logic [63:0] bits, input int n);
      logic [3:0]  prefix, ctrl, addr;
      logic [15:0] data;
      if (n != 32) return 2;
      prefix = bits[31:28];
      ctrl   = bits[27:24];
      addr   = bits[23:20];
      data   = bits[19:4];
      if (prefix != 0) return 2;
      if (ctrl == 4'h9) return 1;
      if (ctrl != 4'h3) return 2;
      if (addr < 8) begin
         m_shadow[addr] = data;
         m_data = data;
         m_chan = addr[2:0];
         return 0;
      end
      if (addr == 4'hF) begin
         for (int i = 0; i < 8; i++) m_shadow[i] = data;
         m_data = data;
         m_chan = 3'd0;
         return 0;
      end
      return 2;
   endfunction

   task automatic check_state(input string tag);
      logic [127:0] flat;
      for (int i = 0; i < 8; i++) flat[i*16 +: 16] = m_shadow[i];
      check_eq({tag, ".data"}, 128'(data_out), 128'(m_data));
      check_eq({tag, ".chan"}, 128'(channel_out), 128'(m_chan));
      check_eq({tag, ".shadow"}, ch_data_out, flat);
   endtask

   // sclk = clk/4, din changes with the sclk rising edge, MSB first.
   // abort_at >= 0 pulls reset low before that bit is sent.
   task automatic send_bits(input logic [63:0] bits, input int n, input int abort_at);
      @(negedge clk);
      nsync = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < n; k++) begin
         if (k == abort_at) begin
            reset_n = 1'b0;
            nsync   = 1'b1;
            sclk    = 1'b1;
            repeat (3) @(negedge clk);
            reset_n = 1'b1;
            return;
         end
         din = bits[n-1-k];
         repeat (2) @(negedge clk);
         sclk = 1'b0;
         repeat (2) @(negedge clk);
         sclk = 1'b1;
      end
      repeat (2) @(negedge clk);
      nsync = 1'b1;
   endtask

   task automatic run_frame(input string tag, input logic [63:0] bits, input int n);
      int unsigned dv0, ref0, err0;
      int kind, lat;
      dv0 = dv_cnt; ref0 = ref_cnt; err0 = err_cnt;
      kind = model_apply(bits, n);
      send_bits(bits, n, -1);
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (lat == 0 && (data_valid_out || ref_set_out || frame_err_out)) lat = i;
      end
      check_eq({tag, ".latency"}, 128'(lat), 128'd4);
      check_eq({tag, ".dv"},  128'(dv_cnt - dv0),   128'(kind == 0));
      check_eq({tag, ".ref"}, 128'(ref_cnt - ref0), 128'(kind == 1));
      check_eq({tag, ".err"}, 128'(err_cnt - err0), 128'(kind == 2));
      check_state(tag);
   endtask

   function automatic logic [63:0] mk(input logic [3:0] p, input logic [3:0] c,
                                      input logic [3:0] a, input logic [15:0] d);
      return 64'({p, c, a, d, 4'h0});
   endfunction

   initial begin
      logic [63:0] fa, fb;
      int sel, nb;
      reset_n = 1'b0;
      nsync   = 1'b1;
      sclk    = 1'b1;
      din     = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      check_eq("reset.pulses", 128'({data_valid_out, ref_set_out, frame_err_out}), 128'd0);
      check_state("reset");
      reset_n = 1'b1;
      repeat (6) @(negedge clk);

      run_frame("write_beef", mk(4'h0, 4'h3, 4'h2, 16'hBEEF), 32);
      run_frame("ref_set",    mk(4'h0, 4'h9, 4'h0, 16'hA000), 32);
      run_frame("short31",    mk(4'h0, 4'h3, 4'h1, 16'h5555) >> 1, 31);
      run_frame("long33",     mk(4'h0, 4'h3, 4'h1, 16'h5555) << 1, 33);
      run_frame("bcast",      mk(4'h0, 4'h3, 4'hF, 16'h1234), 32);
      run_frame("bad_op",     mk(4'h0, 4'h7, 4'h1, 16'h7777), 32);
      run_frame("bad_addr",   mk(4'h0, 4'h3, 4'h9, 16'h9999), 32);
      run_frame("bad_prefix", mk(4'h5, 4'h3, 4'h4, 16'h4444), 32);

      for (int t = 0; t < 24; t++) begin
         sel = int'($urandom_range(0, 6));
         nb  = 32;
         case (sel)
            0, 1: fa = mk(4'h0, 4'h3, 4'($urandom_range(0, 7)), 16'($urandom));
            2:    fa = mk(4'h0, 4'h3, 4'hF, 16'($urandom));
            3:    fa = mk(4'h0, 4'h9, 4'($urandom), 16'($urandom));
            4:    fa = mk(4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom), 16'($urandom));
            5:    fa = mk(4'h0, 4'($urandom), 4'($urandom), 16'($urandom));
            default: begin
               nb = ($urandom_range(0, 1) == 0) ? 31 : 33;
               fa = 64'($urandom) & ((64'd1 << nb) - 64'd1);
            end
         endcase
         run_frame("rand", fa, nb);
      end

      // Back-to-back writes with nsync high for one sclk period.
      fa = mk(4'h0, 4'h3, 4'h5, 16'($urandom));
      fb = mk(4'h0, 4'h3, 4'h6, 16'($urandom));
      dv_log.delete();
      void'(model_apply(fa, 32));
      void'(model_apply(fb, 32));
      send_bits(fa, 32, -1);
      repeat (4) @(negedge clk);
      send_bits(fb, 32, -1);
      repeat (12) @(negedge clk);
      check_eq("b2b.count", 128'(dv_log.size()), 128'd2);
      if (dv_log.size() == 2) begin
         check_eq("b2b.first",  128'(dv_log[0]), 128'(fa[19:4]));
         check_eq("b2b.second", 128'(dv_log[1]), 128'(fb[19:4]));
      end
      check_state("b2b");

      // Reset at bit 17 of a write: no pulse, everything cleared, next frame accepted.
      begin
         int unsigned tot0;
         tot0 = dv_cnt + ref_cnt + err_cnt;
         send_bits(mk(4'h0, 4'h3, 4'h3, 16'hCAFE), 32, 17);
         model_reset();
         repeat (12) @(negedge clk);
         check_eq("abort.pulses", 128'(dv_cnt + ref_cnt + err_cnt - tot0), 128'd0);
         check_state("abort");
      end
      run_frame("after_abort", mk(4'h0, 4'h3, 4'h3, 16'hCAFE), 32);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
